// File: rtl/frame_write_ctrl_if.sv
// Burst write channel between the frame write controller and the DDR2 burst wrapper.
interface frame_write_ctrl_if #(
   parameter int unsigned MEM_DATA_BITS = 64,
   parameter int unsigned ADDR_BITS     = 24
);
   logic                     wr_burst_req;
   logic [9:0]               wr_burst_len;
   logic [ADDR_BITS-1:0]     wr_burst_addr;
   logic                     wr_burst_data_req;
   logic [MEM_DATA_BITS-1:0] wr_burst_data;
   logic                     wr_burst_finish;

   modport master (
      output wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
      input  wr_burst_data_req, wr_burst_finish
   );

   modport slave (
      input  wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
      output wr_burst_data_req, wr_burst_finish
   );
endinterface

// File: rtl/frame_write_ctrl.sv
// Drains the pixel FIFO into DDR2 in fixed-length bursts, rotating among NUM_BUF frame
// buffers at each frame start and publishing the last completely written buffer.
module frame_write_ctrl #(
   parameter int unsigned MEM_DATA_BITS = 64,
   parameter int unsigned ADDR_BITS     = 24,
   parameter int unsigned BURST_LEN     = 128,
   parameter int unsigned FRAME_WORDS   = 230400,
   parameter int unsigned FRAME_STRIDE  = 24'h040000,
   parameter int unsigned NUM_BUF       = 3
) (
   input  logic                     mem_clk,
   input  logic                     rst,
   input  logic                     frame_start,
   input  logic [10:0]              fifo_rdusedw,
   input  logic [MEM_DATA_BITS-1:0] fifo_q,
   output logic                     fifo_rd_en,
   output logic                     fifo_clr,
   frame_write_ctrl_if.master       wr,
   output logic [1:0]               wr_buf,
   output logic [1:0]               done_buf,
   output logic                     frame_done
);

   localparam logic [ADDR_BITS-1:0] FrameWordsA = ADDR_BITS'(FRAME_WORDS);
   localparam logic [ADDR_BITS-1:0] StrideA     = ADDR_BITS'(FRAME_STRIDE);
   localparam logic [ADDR_BITS-1:0] BurstLenA   = ADDR_BITS'(BURST_LEN);
   localparam logic [2:0]           NumBufW     = 3'(NUM_BUF);
   localparam logic [1:0]           LastBuf     = 2'(NUM_BUF - 1);

   typedef enum logic [1:0] {StIdle, StReq, StBurst, StSwitch} state_e;

   state_e               state_q, state_d;
   logic [ADDR_BITS-1:0] word_cnt_q, word_cnt_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [9:0]           len_q, len_d;
   logic [1:0]           wr_buf_q, wr_buf_d;
   logic [1:0]           done_buf_q, done_buf_d;
   logic                 sw_pending_q, sw_pending_d;
   logic                 req_q, req_d;
   logic                 frame_done_q, frame_done_d;

   logic [ADDR_BITS-1:0] remain;
   logic [9:0]           next_len;
   logic                 frame_full;
   logic [2:0]           next_buf;

   // Data path is a straight wire: the FIFO's one-cycle read latency matches the wrapper.
   assign fifo_rd_en       = wr.wr_burst_data_req;
   assign wr.wr_burst_data = fifo_q;
   assign wr.wr_burst_req  = req_q;
   assign wr.wr_burst_len  = len_q;
   assign wr.wr_burst_addr = addr_q;
   assign wr_buf           = wr_buf_q;
   assign done_buf         = done_buf_q;
   assign frame_done       = frame_done_q;
   assign fifo_clr         = (state_q == StSwitch);

   // Remaining-words burst sizing and next buffer selection.
   always_comb begin
      remain     = FrameWordsA - word_cnt_q;
      next_len   = (remain < BurstLenA) ? 10'(remain) : 10'(BURST_LEN);
      frame_full = (word_cnt_q == FrameWordsA);
      next_buf   = {1'b0, wr_buf_q} + 3'd1;
      if (next_buf >= NumBufW) next_buf = 3'd0;
      // Never start overwriting the buffer the read side is currently allowed to show.
      if ((NUM_BUF >= 3) && (next_buf[1:0] == done_buf_q)) begin
         next_buf = next_buf + 3'd1;
         if (next_buf >= NumBufW) next_buf = 3'd0;
      end
   end

   // Next-state and register-update logic for the burst/switch sequencer.
   always_comb begin
      state_d      = state_q;
      word_cnt_d   = word_cnt_q;
      addr_d       = addr_q;
      len_d        = len_q;
      wr_buf_d     = wr_buf_q;
      done_buf_d   = done_buf_q;
      sw_pending_d = sw_pending_q;
      req_d        = req_q;
      frame_done_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (sw_pending_q || frame_start) begin
               state_d = StSwitch;
            end else if (!frame_full && ({1'b0, next_len} <= fifo_rdusedw)) begin
               state_d = StReq;
               len_d   = next_len;
               addr_d  = ADDR_BITS'(wr_buf_q) * StrideA + word_cnt_q;
               req_d   = 1'b1;
            end
         end
         StReq: begin
            if (frame_start) sw_pending_d = 1'b1;
            if (wr.wr_burst_data_req) begin
               req_d   = 1'b0;
               state_d = StBurst;
            end
         end
         StBurst: begin
            if (frame_start) sw_pending_d = 1'b1;
            if (wr.wr_burst_finish) begin
               word_cnt_d = word_cnt_q + ADDR_BITS'(len_q);
               if (word_cnt_d == FrameWordsA) begin
                  frame_done_d = 1'b1;
                  done_buf_d   = wr_buf_q;
               end
               state_d = StIdle;
            end
         end
         StSwitch: begin
            sw_pending_d = 1'b0;
            // A partial frame is rewritten into the same buffer.
            if (frame_full) wr_buf_d = next_buf[1:0];
            word_cnt_d = '0;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with asynchronous reset.
   always_ff @(posedge mem_clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         word_cnt_q   <= '0;
         addr_q       <= '0;
         len_q        <= '0;
         wr_buf_q     <= '0;
         done_buf_q   <= LastBuf;
         sw_pending_q <= 1'b0;
         req_q        <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         word_cnt_q   <= word_cnt_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         wr_buf_q     <= wr_buf_d;
         done_buf_q   <= done_buf_d;
         sw_pending_q <= sw_pending_d;
         req_q        <= req_d;
         frame_done_q <= frame_done_d;
      end
   end

endmodule

// File: tb/tb_frame_write_ctrl.sv
// Randomized bench: FIFO + burst wrapper models driven on the falling edge, with a
// transaction-level reference for burst sizes, addresses, buffer rotation and data order.
module tb_frame_write_ctrl;
   localparam int BL = 16;
   localparam int FW = 40;
   localparam int FS = 64;
   localparam int NB = 3;
   localparam int AB = 24;
   localparam int DB = 32;

   logic          mem_clk, rst, frame_start;
   logic [10:0]   fifo_rdusedw;
   logic [DB-1:0] fifo_q;
   logic          fifo_rd_en, fifo_clr, frame_done;
   logic [1:0]    wr_buf, done_buf;

   frame_write_ctrl_if #(.MEM_DATA_BITS(DB), .ADDR_BITS(AB)) wr_if ();

   frame_write_ctrl #(
      .MEM_DATA_BITS(DB), .ADDR_BITS(AB), .BURST_LEN(BL), .FRAME_WORDS(FW),
      .FRAME_STRIDE(FS), .NUM_BUF(NB)
   ) dut (
      .mem_clk(mem_clk), .rst(rst), .frame_start(frame_start), .fifo_rdusedw(fifo_rdusedw),
      .fifo_q(fifo_q), .fifo_rd_en(fifo_rd_en), .fifo_clr(fifo_clr), .wr(wr_if.master),
      .wr_buf(wr_buf), .done_buf(done_buf), .frame_done(frame_done)
   );

   initial mem_clk = 1'b0;
   always #5 mem_clk = ~mem_clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int next_buf_of(input int b, input int d);
      int n;
      n = (b + 1) % NB;
      if (NB >= 3 && n == d) n = (n + 1) % NB;
      return n;
   endfunction

   // Environment and reference state.
   logic [DB-1:0] fq[$];
   int unsigned push_val = 0, push_total = 0, pushed = 0;
   int ws = 0, delay = 0, beats = 0, w_len = 0, cyc = 0;
   int busy = 0, cap_pend = 0, cap_off = 0, fd_exp = 0, chk_buf = 0;
   int m_cnt = 0, m_buf = 0, m_done = NB - 1, m_sw = 0;
   int unsigned frame_first = 0;
   int req_cnt = 0, fd_cnt = 0, clr_cnt = 0, fin_cyc = 0, clr_cyc = 0;

   // FIFO and wrapper models; inputs change on the falling edge only.
   always @(negedge mem_clk) begin
      cyc++;
      if (rst) begin
         fq.delete();
         pushed = push_total;
         fifo_rdusedw = '0;
         fifo_q = '0;
         wr_if.wr_burst_data_req = 1'b0;
         wr_if.wr_burst_finish = 1'b0;
         ws = 0; busy = 0; cap_pend = 0; fd_exp = 0; chk_buf = 0;
         m_cnt = 0; m_buf = 0; m_done = NB - 1; m_sw = 0;
         frame_first = push_val;
      end else begin
         if (frame_done || fd_exp != 0) begin
            check("frame_done", frame_done, fd_exp != 0);
            if (fd_exp != 0) check("done_buf", done_buf, m_done);
            if (frame_done) fd_cnt++;
         end
         fd_exp = 0;
         if (chk_buf != 0) begin
            check("wr_buf_after_switch", wr_buf, m_buf);
            check("wr_buf_ne_done", wr_buf != done_buf, 1);
            chk_buf = 0;
         end
         wr_if.wr_burst_finish = 1'b0;
         if (cap_pend != 0) begin
            check("wdata", wr_if.wr_burst_data, DB'(frame_first + cap_off));
            cap_pend = 0;
         end
         if (fifo_rd_en) fifo_q = (fq.size() > 0) ? fq.pop_front() : '0;
         if (wr_if.wr_burst_data_req) begin
            cap_pend = 1;
            cap_off  = m_cnt + beats;
            beats++;
         end
         case (ws)
            0: if (wr_if.wr_burst_req) begin
               check("req_len", wr_if.wr_burst_len, (FW - m_cnt < BL) ? FW - m_cnt : BL);
               check("req_addr", wr_if.wr_burst_addr, m_buf * FS + m_cnt);
               w_len = int'(wr_if.wr_burst_len);
               beats = 0; busy = 1; req_cnt++;
               delay = $urandom_range(0, 3);
               ws = 1;
            end
            1: if (delay == 0) begin
               wr_if.wr_burst_data_req = 1'b1;
               ws = 2;
            end else delay--;
            2: if (beats >= w_len) begin
               wr_if.wr_burst_data_req = 1'b0;
               delay = $urandom_range(0, 2);
               ws = 3;
            end else wr_if.wr_burst_data_req = ($urandom_range(0, 3) != 0);
            default: if (delay == 0) begin
               wr_if.wr_burst_finish = 1'b1;
               fin_cyc = cyc;
               m_cnt += w_len;
               if (m_cnt == FW) begin
                  fd_exp = 1;
                  m_done = m_buf;
               end
               busy = 0; ws = 0;
            end else delay--;
         endcase
         if (frame_start) m_sw = 1;
         if (fifo_clr) begin
            check("clr_expected", m_sw, 1);
            check("clr_no_burst", busy, 0);
            if (m_cnt == FW) m_buf = next_buf_of(m_buf, m_done);
            m_cnt = 0; m_sw = 0; chk_buf = 1;
            clr_cnt++; clr_cyc = cyc;
            fq.delete();
            frame_first = push_val;
         end
         while (pushed < push_total) begin
            fq.push_back(DB'(push_val));
            push_val++;
            pushed++;
         end
         fifo_rdusedw = 11'(fq.size());
      end
   end

   task automatic tick();
      @(posedge mem_clk);
      #2;
   endtask

   task automatic pulse_start();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   function automatic int cur(input int which);
      case (which)
         0: return req_cnt;
         1: return fd_cnt;
         2: return clr_cnt;
         default: return (ws == 2) ? 1 : 0;
      endcase
   endfunction

   task automatic wait_until(input string tag, input int which, input int target);
      int t;
      t = 0;
      while (t < 400 && cur(which) < target) begin
         tick();
         t++;
      end
      check(tag, cur(which) >= target, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"}, wr_if.wr_burst_req, 0);
      check({tag, "_len"}, wr_if.wr_burst_len, 0);
      check({tag, "_addr"}, wr_if.wr_burst_addr, 0);
      check({tag, "_clr"}, fifo_clr, 0);
      check({tag, "_fd"}, frame_done, 0);
      check({tag, "_wr_buf"}, wr_buf, 0);
      check({tag, "_done_buf"}, done_buf, NB - 1);
   endtask

   initial begin
      int eb, ed, base, t;
      rst = 1'b1;
      frame_start = 1'b0;
      wr_if.wr_burst_data_req = 1'b0;
      wr_if.wr_burst_finish = 1'b0;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      repeat (2) tick();

      // Burst threshold: 15 words are not enough, the 16th triggers a request next cycle.
      push_total += 15;
      repeat (6) begin
         tick();
         check("no_req_below_thresh", wr_if.wr_burst_req, 0);
      end
      push_total += 1;
      tick();
      check("req_at_thresh", wr_if.wr_burst_req, 1);
      check("first_len", wr_if.wr_burst_len, 16);
      check("first_addr", wr_if.wr_burst_addr, 0);
      push_total += 24;
      wait_until("frame0_done", 1, 1);
      tick();
      check("done_buf_frame0", done_buf, 0);
      pulse_start();
      wait_until("switch0", 2, 1);
      tick();
      check("wr_buf_after_frame0", wr_buf, 1);

      // Frame start during the second burst: partial frame, same buffer, no frame_done.
      base = req_cnt;
      push_total += 40;
      wait_until("second_burst", 0, base + 2);
      pulse_start();
      wait_until("switch_partial", 2, 2);
      check("clr_after_finish", clr_cyc - fin_cyc, 2);
      tick();
      check("wr_buf_partial", wr_buf, 1);
      check("no_fd_partial", fd_cnt, 1);

      // Three complete frames with random FIFO fill and a few surplus words each.
      eb = 1;
      for (int f = 0; f < 3; f++) begin
         int goal;
         goal = push_total + FW + $urandom_range(0, 6);
         while (push_total < goal) begin
            t = $urandom_range(1, 9);
            push_total += (goal - push_total < t) ? goal - push_total : t;
            tick();
         end
         wait_until("full_frame", 1, fd_cnt + 1);
         tick();
         check("done_buf_seq", done_buf, eb);
         ed = eb;
         pulse_start();
         wait_until("switch_full", 2, clr_cnt + 1);
         tick();
         eb = next_buf_of(eb, ed);
         check("wr_buf_seq", wr_buf, eb);
         check("wr_buf_ne_done_seq", wr_buf != done_buf, 1);
      end

      // Reset in the middle of a burst, then a fresh frame from address 0.
      push_total += 40;
      wait_until("in_burst", 3, 1);
      rst = 1'b1;
      #1;
      check_reset_outputs("mid_burst_reset");
      tick();
      rst = 1'b0;
      tick();
      pulse_start();
      wait_until("switch_after_rst", 2, clr_cnt + 1);
      push_total += 40;
      t = 0;
      while (t < 50 && !wr_if.wr_burst_req) begin
         tick();
         t++;
      end
      check("req_after_rst", wr_if.wr_burst_req, 1);
      check("addr_after_rst", wr_if.wr_burst_addr, 0);
      wait_until("frame_after_rst", 1, fd_cnt + 1);
      tick();
      check("done_buf_after_rst", done_buf, 0);
      repeat (4) tick();
      check("no_pending_switch", m_sw, 0);
      check("no_open_burst", busy, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
